piezo_decode: RTL and testbench

PIEZO_DECODE -- requirements
Module: piezo_decode

---
 rtl/piezo_decode.sv | 228 ++++++++++++++++++++++
 tb/tb_piezo_decode.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_decode.sv
// piezo_decode
//   Recovers the note sequence played on a piezo buzzer by measuring the
//   rising-to-rising period of its drive signal, and recognises three jingles
//   (steer, fast, battery) from the order of the confirmed notes.
//
// Parameters
//   FAST_SIM  : nonzero divides all nominal periods and the silence timeout
//               by 512 so simulations stay short.
//   TOL_SHIFT : match window is nominal +/- (nominal >> TOL_SHIFT), at least 1.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   piezo      in   square-wave tone from the piezo driver
//   piezo_n    in   complement tone (only checked with PIEZO_DIFF_CHK_EN)
//   note       out  [2:0] confirmed note: 0 silence, 1 G6, 2 C7, 3 E7, 4 G7
//   note_vld   out  one-cycle pulse whenever note changes
//   period     out  [15:0] last measured period in clocks
//   steer_tune out  one-cycle pulse, steer jingle recognised
//   fast_tune  out  one-cycle pulse, fast jingle recognised
//   batt_tune  out  one-cycle pulse, battery jingle recognised
//   diff_err   out  sticky complement-mismatch flag
//
// Optional feature: define PIEZO_DIFF_CHK_EN to enable the piezo/piezo_n
// complement check; otherwise diff_err is tied low and piezo_n is ignored.

module piezo_decode #(
    parameter int FAST_SIM  = 1,
    parameter int TOL_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        piezo,
    input  logic        piezo_n,
    output logic [2:0]  note,
    output logic        note_vld,
    output logic [15:0] period,
    output logic        steer_tune,
    output logic        fast_tune,
    output logic        batt_tune,
    output logic        diff_err
);

    function automatic int tol_of(input int nom);
        int t;
        t = nom >> TOL_SHIFT;
        return (t < 1) ? 1 : t;
    endfunction

    localparam int DIV    = (FAST_SIM != 0) ? 512 : 1;
    localparam int G6_NOM = 31888 / DIV;
    localparam int C7_NOM = 23890 / DIV;
    localparam int E7_NOM = 18961 / DIV;
    localparam int G7_NOM = 15944 / DIV;
    localparam int SIL_NOM = 63776 / DIV;

    localparam logic [15:0] G6_LO = 16'(G6_NOM - tol_of(G6_NOM));
    localparam logic [15:0] G6_HI = 16'(G6_NOM + tol_of(G6_NOM));
    localparam logic [15:0] C7_LO = 16'(C7_NOM - tol_of(C7_NOM));
    localparam logic [15:0] C7_HI = 16'(C7_NOM + tol_of(C7_NOM));
    localparam logic [15:0] E7_LO = 16'(E7_NOM - tol_of(E7_NOM));
    localparam logic [15:0] E7_HI = 16'(E7_NOM + tol_of(E7_NOM));
    localparam logic [15:0] G7_LO = 16'(G7_NOM - tol_of(G7_NOM));
    localparam logic [15:0] G7_HI = 16'(G7_NOM + tol_of(G7_NOM));
    localparam logic [15:0] SIL_CNT = 16'(SIL_NOM);

    localparam logic [2:0] N_SIL = 3'd0;
    localparam logic [2:0] N_G6  = 3'd1;
    localparam logic [2:0] N_C7  = 3'd2;
    localparam logic [2:0] N_E7  = 3'd3;
    localparam logic [2:0] N_G7  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, F_G6, F_C7, F_E7, S_G7, S_E7,
        B_G7, B_E7, B_G7B, B_E7B, B_C7
    } tune_state_t;

    logic        piezo_q;
    logic        piezo_prev;
    logic        rise;
    logic [15:0] cnt;
    logic        first_seen;
    logic        pend_vld;
    logic [2:0]  pend_cls;
    logic [2:0]  cls;
    tune_state_t state;
    tune_state_t state_nxt;

    assign rise = piezo_q & ~piezo_prev;

    // Classify the running count as a note; it is only used at a rise, when
    // the count equals the period that just ended. N_SIL means unmatched.
    always_comb begin
        cls = N_SIL;
        if (cnt >= G6_LO && cnt <= G6_HI)
            cls = N_G6;
        else if (cnt >= C7_LO && cnt <= C7_HI)
            cls = N_C7;
        else if (cnt >= E7_LO && cnt <= E7_HI)
            cls = N_E7;
        else if (cnt >= G7_LO && cnt <= G7_HI)
            cls = N_G7;
    end

    // Period measurement, two-in-a-row note confirmation and silence timeout.
    // The first rise after reset or silence has no valid start point, so it
    // only arms the measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            piezo_q    <= 1'b0;
            piezo_prev <= 1'b0;
            cnt        <= 16'd0;
            first_seen <= 1'b0;
            pend_vld   <= 1'b0;
            pend_cls   <= N_SIL;
            note       <= N_SIL;
            note_vld   <= 1'b0;
            period     <= 16'd0;
        end else begin
            piezo_q    <= piezo;
            piezo_prev <= piezo_q;
            note_vld   <= 1'b0;
            if (rise) begin
                cnt <= 16'd1;
                if (!first_seen) begin
                    first_seen <= 1'b1;
                end else begin
                    period <= cnt;
                    if (cls == N_SIL) begin
                        pend_vld <= 1'b0;
                    end else begin
                        pend_vld <= 1'b1;
                        pend_cls <= cls;
                        if (pend_vld && pend_cls == cls && cls != note) begin
                            note     <= cls;
                            note_vld <= 1'b1;
                        end
                    end
                end
            end else begin
                if (cnt != 16'hFFFF)
                    cnt <= cnt + 16'd1;
                // cnt passes SIL_CNT exactly once per gap, so this fires once
                if (cnt == SIL_CNT) begin
                    first_seen <= 1'b0;
                    pend_vld   <= 1'b0;
                    if (note != N_SIL) begin
                        note     <= N_SIL;
                        note_vld <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Tune recogniser, advanced only on note changes. The fallback handles
    // any note that breaks a sequence; it is overridden by the expected step.
    // Pulses are combinational so they line up with the completing note_vld.
    always_comb begin
        state_nxt  = state;
        steer_tune = 1'b0;
        fast_tune  = 1'b0;
        batt_tune  = 1'b0;
        if (note_vld) begin
            if (note == N_G6)
                state_nxt = F_G6;
            else if (note == N_G7)
                state_nxt = B_G7;
            else
                state_nxt = IDLE;
            case (state)
                F_G6:  if (note == N_C7) state_nxt = F_C7;
                F_C7:  if (note == N_E7) state_nxt = F_E7;
                F_E7: begin
                    if (note == N_G7)
                        state_nxt = S_G7;
                    else if (note == N_G6 || note == N_SIL)
                        fast_tune = 1'b1;
                end
                S_G7:  if (note == N_E7) state_nxt = S_E7;
                S_E7: begin
                    if (note == N_G7) begin
                        steer_tune = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                B_G7:  if (note == N_E7) state_nxt = B_E7;
                B_E7:  if (note == N_G7) state_nxt = B_G7B;
                B_G7B: if (note == N_E7) state_nxt = B_E7B;
                B_E7B: if (note == N_C7) state_nxt = B_C7;
                B_C7:  if (note == N_G6) batt_tune = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PIEZO_DIFF_CHK_EN
    logic piezo_n_q;
    logic same_q;

    // piezo_n_q resets to the complement of piezo_q so the reset values
    // themselves never look like a mismatch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            piezo_n_q <= 1'b1;
            same_q    <= 1'b0;
            diff_err  <= 1'b0;
        end else begin
            piezo_n_q <= piezo_n;
            same_q    <= (piezo_n_q == piezo_q);
            if (same_q && (piezo_n_q == piezo_q))
                diff_err <= 1'b1;
        end
    end
`else
    logic unused_piezo_n;
    assign unused_piezo_n = piezo_n;
    assign diff_err = 1'b0;
`endif

endmodule

// File: tb/tb_piezo_decode.sv
// Testbench for piezo_decode (FAST_SIM=1, TOL_SHIFT=4).
// Nominal periods G6 62, C7 46, E7 37, G7 31; silence after 124 idle clocks.

module tb_piezo_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        piezo;
    logic        piezo_n;
    logic [2:0]  note;
    logic        note_vld;
    logic [15:0] period;
    logic        steer_tune;
    logic        fast_tune;
    logic        batt_tune;
    logic        diff_err;

    int checks   = 0;
    int failures = 0;

`ifdef PIEZO_DIFF_CHK_EN
    localparam logic EXP_DIFF = 1'b1;
`else
    localparam logic EXP_DIFF = 1'b0;
`endif

    localparam int P_G6 = 62;
    localparam int P_C7 = 46;
    localparam int P_E7 = 37;
    localparam int P_G7 = 31;

    always #5 clk = ~clk;

    piezo_decode #(
        .FAST_SIM  (1),
        .TOL_SHIFT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .piezo      (piezo),
        .piezo_n    (piezo_n),
        .note       (note),
        .note_vld   (note_vld),
        .period     (period),
        .steer_tune (steer_tune),
        .fast_tune  (fast_tune),
        .batt_tune  (batt_tune),
        .diff_err   (diff_err)
    );

    // Pulse monitor, sampling on the falling edge.
    int       nv_cnt = 0, fast_cnt = 0, steer_cnt = 0, batt_cnt = 0;
    int       orphan_cnt = 0, multi_cnt = 0, wide_cnt = 0;
    logic [2:0] last_nv_note = 3'd0, fast_note = 3'd0, steer_note = 3'd0, batt_note = 3'd0;
    logic     prev_nv = 1'b0, prev_fast = 1'b0, prev_steer = 1'b0, prev_batt = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (note_vld) begin
                nv_cnt       <= nv_cnt + 1;
                last_nv_note <= note;
            end
            if (fast_tune) begin
                fast_cnt  <= fast_cnt + 1;
                fast_note <= note;
            end
            if (steer_tune) begin
                steer_cnt  <= steer_cnt + 1;
                steer_note <= note;
            end
            if (batt_tune) begin
                batt_cnt  <= batt_cnt + 1;
                batt_note <= note;
            end
            if ((fast_tune || steer_tune || batt_tune) && !note_vld)
                orphan_cnt <= orphan_cnt + 1;
            if ((32'(fast_tune) + 32'(steer_tune) + 32'(batt_tune)) > 1)
                multi_cnt <= multi_cnt + 1;
            if ((note_vld && prev_nv) || (fast_tune && prev_fast) ||
                (steer_tune && prev_steer) || (batt_tune && prev_batt))
                wide_cnt <= wide_cnt + 1;
        end
        prev_nv    <= note_vld;
        prev_fast  <= fast_tune;
        prev_steer <= steer_tune;
        prev_batt  <= batt_tune;
    end

    int nv0, fast0, steer0, batt0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snapshot();
        nv0    = nv_cnt;
        fast0  = fast_cnt;
        steer0 = steer_cnt;
        batt0  = batt_cnt;
    endtask

    // n full periods of a square wave, each starting with a rising edge
    task automatic applyStimulus(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            piezo   = 1'b1;
            piezo_n = 1'b0;
            tick(p / 2);
            piezo   = 1'b0;
            piezo_n = 1'b1;
            tick(p - p / 2);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_note"},     32'(note),       32'd0);
        checkOutput({tag, "_note_vld"}, 32'(note_vld),   32'd0);
        checkOutput({tag, "_period"},   32'(period),     32'd0);
        checkOutput({tag, "_steer"},    32'(steer_tune), 32'd0);
        checkOutput({tag, "_fast"},     32'(fast_tune),  32'd0);
        checkOutput({tag, "_batt"},     32'(batt_tune),  32'd0);
        checkOutput({tag, "_diff_err"}, 32'(diff_err),   32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        piezo   = 1'b0;
        piezo_n = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // G6 square wave: confirmed by the third rising edge
        $display("[TB] G6 tone");
        snapshot();
        applyStimulus(P_G6, 2);
        checkOutput("g6_after_two_edges", 32'(note), 32'd0);
        applyStimulus(P_G6, 3);
        checkOutput("g6_note",      32'(note),         32'd1);
        checkOutput("g6_nv_count",  32'(nv_cnt - nv0), 32'd1);
        checkOutput("g6_nv_note",   32'(last_nv_note), 32'd1);
        checkOutput("g6_period",    32'(period),       32'd62);
        tick(140);
        checkOutput("g6_silence_note",  32'(note),           32'd0);
        checkOutput("g6_silence_nv",    32'(nv_cnt - nv0),   32'd2);
        checkOutput("g6_silence_fast",  32'(fast_cnt - fast0), 32'd0);

        // Fast tune: G6 C7 E7 then silence
        $display("[TB] fast tune");
        snapshot();
        applyStimulus(P_G6, 3);
        applyStimulus(P_C7, 3);
        applyStimulus(P_E7, 3);
        checkOutput("fast_note_e7",  32'(note),              32'd3);
        checkOutput("fast_early",    32'(fast_cnt - fast0),  32'd0);
        tick(140);
        checkOutput("fast_count",    32'(fast_cnt - fast0),  32'd1);
        checkOutput("fast_on_note",  32'(fast_note),         32'd0);
        checkOutput("fast_steer",    32'(steer_cnt - steer0), 32'd0);
        checkOutput("fast_batt",     32'(batt_cnt - batt0),  32'd0);
        checkOutput("fast_nv_count", 32'(nv_cnt - nv0),     32'd4);

        // Steer tune: G6 C7 E7 G7 E7 G7
        $display("[TB] steer tune");
        snapshot();
        applyStimulus(P_G6, 3);
        applyStimulus(P_C7, 3);
        applyStimulus(P_E7, 3);
        applyStimulus(P_G7, 3);
        applyStimulus(P_E7, 3);
        applyStimulus(P_G7, 3);
        checkOutput("steer_count",   32'(steer_cnt - steer0), 32'd1);
        checkOutput("steer_on_note", 32'(steer_note),         32'd4);
        checkOutput("steer_fast",    32'(fast_cnt - fast0),   32'd0);
        tick(140);
        checkOutput("steer_nv_count", 32'(nv_cnt - nv0),      32'd7);
        checkOutput("steer_fast_end", 32'(fast_cnt - fast0),  32'd0);

        // Battery tune: G7 E7 G7 E7 C7 G6
        $display("[TB] battery tune");
        snapshot();
        applyStimulus(P_G7, 3);
        applyStimulus(P_E7, 3);
        applyStimulus(P_G7, 3);
        applyStimulus(P_E7, 3);
        applyStimulus(P_C7, 3);
        applyStimulus(P_G6, 3);
        checkOutput("batt_count",   32'(batt_cnt - batt0),   32'd1);
        checkOutput("batt_on_note", 32'(batt_note),          32'd1);
        checkOutput("batt_steer",   32'(steer_cnt - steer0), 32'd0);
        checkOutput("batt_fast",    32'(fast_cnt - fast0),   32'd0);
        tick(140);
        checkOutput("batt_nv_count", 32'(nv_cnt - nv0),      32'd7);

        // Out-of-window period 40 keeps E7; then complement check
        $display("[TB] unmatched period and complement check");
        snapshot();
        applyStimulus(P_E7, 3);
        applyStimulus(40, 3);
        checkOutput("p40_note",     32'(note),          32'd3);
        checkOutput("p40_period",   32'(period),        32'd40);
        checkOutput("p40_nv_count", 32'(nv_cnt - nv0),  32'd1);
        checkOutput("diff_before",  32'(diff_err),      32'd0);
        piezo_n = 1'b0;
        tick(1);
        piezo_n = 1'b1;
        tick(3);
        checkOutput("diff_one_cycle", 32'(diff_err),    32'd0);
        piezo_n = 1'b0;
        tick(4);
        piezo_n = 1'b1;
        tick(2);
        checkOutput("diff_two_cycles", 32'(diff_err),   32'(EXP_DIFF));
        tick(140);
        checkOutput("diff_sticky",  32'(diff_err),      32'(EXP_DIFF));
        checkOutput("p40_silence",  32'(note),          32'd0);

        // Reset in the middle of the steer tune
        $display("[TB] mid-tune reset");
        snapshot();
        applyStimulus(P_G6, 3);
        applyStimulus(P_C7, 3);
        applyStimulus(P_E7, 3);
        applyStimulus(P_G7, 3);
        checkOutput("pre_reset_note", 32'(note), 32'd4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_all_zero("mid_reset");
        nv0 = nv_cnt;
        applyStimulus(P_E7, 3);
        applyStimulus(P_G7, 3);
        tick(140);
        checkOutput("mid_reset_steer", 32'(steer_cnt - steer0), 32'd0);
        checkOutput("mid_reset_fast",  32'(fast_cnt - fast0),   32'd0);
        checkOutput("mid_reset_batt",  32'(batt_cnt - batt0),   32'd0);
        checkOutput("mid_reset_nv",    32'(nv_cnt - nv0),       32'd3);

        // Pulse shape over the whole run
        checkOutput("pulse_orphan", 32'(orphan_cnt), 32'd0);
        checkOutput("pulse_multi",  32'(multi_cnt),  32'd0);
        checkOutput("pulse_wide",   32'(wide_cnt),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
